// File: rtl/countdown_timer_pkg.sv
// Shared game package: countdown states and 7-segment digit codes.
// The winner display reuses the segment constants and decoder.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cd_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Link between the game FSM (master) and the countdown timer (slave).
interface countdown_timer_if #(
    parameter int N_STEPS = 3
);
    logic               cd_rst;
    logic               cd_done;
    logic               cd_active;
    logic [N_STEPS-1:0] cd_leds;
    logic [6:0]         seg_out;

    modport master (
        output cd_rst,
        input  cd_done,
        input  cd_active,
        input  cd_leds,
        input  seg_out
    );

    modport slave (
        input  cd_rst,
        output cd_done,
        output cd_active,
        output cd_leds,
        output seg_out
    );
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: pulses tick on the last cycle of each CLK_DIV window.
module tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_in_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/countdown_timer.sv
// Pre-game countdown: N_STEPS ticks of CLK_DIV clocks, LED bar + digit,
// then a held cd_done level until the game FSM re-asserts cd_rst.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int N_STEPS = 3
) (
    input logic                clk,
    input logic                rst_in_n,
    countdown_timer_if.slave   cd
);
    localparam int RW = $clog2(N_STEPS + 1);

    cd_state_e          state_q, state_d;
    logic [RW-1:0]      remain_q, remain_d;
    logic               done_q, done_d;
    logic               active_q, active_d;
    logic [N_STEPS-1:0] leds_q, leds_d;
    logic [6:0]         seg_q, seg_d;
    logic               tick;
    logic               tg_clr;
    logic               tg_en;

    // Clearing on cd_rst too keeps the prescaler at zero through an abort.
    assign tg_clr = cd.cd_rst || (state_q != RUN);
    assign tg_en  = !cd.cd_rst && (state_q == RUN);

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .clr      (tg_clr),
        .en       (tg_en),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q  <= HOLD;
            remain_q <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
            leds_q   <= '0;
            seg_q    <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            active_q <= active_d;
            leds_q   <= leds_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (cd.cd_rst) begin
            state_d  = HOLD;
            remain_d = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    state_d  = RUN;
                    remain_d = RW'(N_STEPS);
                end
                RUN: begin
                    if (tick) begin
                        if (remain_q <= RW'(1)) begin
                            state_d  = DONE;
                            remain_d = '0;
                        end else begin
                            remain_d = remain_q - RW'(1);
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d  = HOLD;
                    remain_d = '0;
                end
            endcase
        end
    end

    // Decoded from next state so the output flops line up with state_q.
    always_comb begin
        done_d   = 1'b0;
        active_d = 1'b0;
        leds_d   = '0;
        seg_d    = SEG_BLANK;
        unique case (state_d)
            RUN: begin
                active_d = 1'b1;
                for (int i = 0; i < N_STEPS; i++) begin
                    leds_d[i] = (i < int'(remain_d));
                end
                seg_d = seg_decode(4'(remain_d));
            end
            DONE: begin
                done_d = 1'b1;
                seg_d  = SEG_0;
            end
            default: begin
            end
        endcase
    end

    assign cd.cd_done   = done_q;
    assign cd.cd_active = active_q;
    assign cd.cd_leds   = leds_q;
    assign cd.seg_out   = seg_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at three parameter points.
// Expected snapshots are queued per edge and checked 3ns after it.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst_in_n;
    always #5 clk = ~clk;

    countdown_timer_if #(.N_STEPS(3)) if0 ();
    countdown_timer_if #(.N_STEPS(1)) if1 ();
    countdown_timer_if #(.N_STEPS(9)) if2 ();

    countdown_timer #(.CLK_DIV(4), .N_STEPS(3)) dut0 (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .cd       (if0)
    );
    countdown_timer #(.CLK_DIV(2), .N_STEPS(1)) dut1 (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .cd       (if1)
    );
    countdown_timer #(.CLK_DIV(5), .N_STEPS(9)) dut2 (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .cd       (if2)
    );

    typedef struct {
        int          cyc;
        int          id;
        string       tag;
        logic [17:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    localparam logic [17:0] EXP_HOLD = 18'h0;
    localparam logic [17:0] EXP_DONE = {1'b1, 1'b0, 9'h000, 7'h3F};

    logic [17:0] obs0, obs1, obs2;
    assign obs0 = {if0.cd_done, if0.cd_active, 9'(if0.cd_leds), if0.seg_out};
    assign obs1 = {if1.cd_done, if1.cd_active, 9'(if1.cd_leds), if1.seg_out};
    assign obs2 = {if2.cd_done, if2.cd_active, 9'(if2.cd_leds), if2.seg_out};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] get_obs(input int id);
        case (id)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic logic [17:0] exp_run(input int r);
        return {1'b0, 1'b1, 9'((1 << r) - 1), seg_tbl[r]};
    endfunction

    task automatic sb_push(input int c, input int id, input string tag,
                           input logic [17:0] e);
        sb_t s;
        s.cyc = c;
        s.id  = id;
        s.tag = $sformatf("d%0d_%s_c%0d", id, tag, c);
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic sb_flush(input int id, input int from);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].id == id && sbq[i].cyc >= from) sbq.delete(i);
        end
    endtask

    // Release sampled at edge c+1 (E0); decrements at E0 + k*div.
    task automatic push_run(input int id, input int c, input int n,
                            input int div);
        for (int k = 0; k <= n; k++) begin
            if (k < n) sb_push(c + 1 + k * div, id, "run", exp_run(n - k));
            else       sb_push(c + 1 + k * div, id, "done", EXP_DONE);
        end
        for (int k = 1; k <= n; k++) begin
            sb_push(c + k * div, id, "pre", exp_run(n - k + 1));
        end
    endtask

    always @(posedge clk) begin
        #3;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc < cyc) begin
                chk({sbq[i].tag, "_late"}, 32'd0, 32'd1);
                sbq.delete(i);
            end else if (sbq[i].cyc == cyc) begin
                chk(sbq[i].tag, 32'(get_obs(sbq[i].id)), 32'(sbq[i].exp));
                sbq.delete(i);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_in_n   = 1'b0;
        if0.cd_rst = 1'b1;
        if1.cd_rst = 1'b1;
        if2.cd_rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int id = 0; id < 3; id++) sb_push(cyc + 1, id, "rst", EXP_HOLD);
        @(negedge clk);
        rst_in_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_push(cyc + 1, 0, "hold", EXP_HOLD);
            @(negedge clk);
        end

        // normal countdown
        if0.cd_rst = 1'b0;
        push_run(0, cyc, 3, 4);
        repeat (13) @(negedge clk);

        // sit in DONE, then clear
        for (int i = 1; i <= 50; i += 7) sb_push(cyc + i, 0, "dhold", EXP_DONE);
        repeat (50) @(negedge clk);
        if0.cd_rst = 1'b1;
        sb_push(cyc + 1, 0, "clr", EXP_HOLD);
        repeat (2) @(negedge clk);

        // abort mid-run, then full restart
        if0.cd_rst = 1'b0;
        push_run(0, cyc, 3, 4);
        repeat (5) @(negedge clk);
        sb_flush(0, cyc + 1);
        if0.cd_rst = 1'b1;
        sb_push(cyc + 1, 0, "abort", EXP_HOLD);
        @(negedge clk);
        if0.cd_rst = 1'b0;
        push_run(0, cyc, 3, 4);
        repeat (13) @(negedge clk);

        // async reset between edges
        if0.cd_rst = 1'b1;
        @(negedge clk);
        if0.cd_rst = 1'b0;
        push_run(0, cyc, 3, 4);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        sb_flush(0, cyc);
        rst_in_n = 1'b0;
        for (int id = 0; id < 3; id++) sb_push(cyc, id, "arst", EXP_HOLD);
        @(negedge clk);
        rst_in_n = 1'b1;
        push_run(0, cyc, 3, 4);
        repeat (13) @(negedge clk);

        // parameter corners
        if0.cd_rst = 1'b1;
        if1.cd_rst = 1'b0;
        if2.cd_rst = 1'b0;
        push_run(1, cyc, 1, 2);
        push_run(2, cyc, 9, 5);
        repeat (48) @(negedge clk);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Pre-game countdown stage feeding the arbiter game FSM. While the FSM holds `cd_rst` high the block is idle and dark. Once `cd_rst` is released it counts down N_STEPS ticks of CLK_DIV clocks each, driving an LED bar and a 7-segment digit, then raises `cd_done` so the FSM can enter IDLE and start accepting player requests.

## Interface
- `CLK_DIV`, default 1000: clk cycles per countdown step; legal range >= 2.
- `N_STEPS`, default 3: number of countdown steps; legal range 1..9, so the count always fits one digit.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_in_n`  in  1  reset, asynchronous, active-low.
- `cd_rst`  in  1  synchronous hold/restart from the game FSM, active-high.
- `cd_done`  out  1  countdown finished; level, held until `cd_rst` is asserted.
- `cd_active`  out  1  high while counting.
- `cd_leds`  out  N_STEPS  thermometer bar of remaining steps; bit 0 is the last LED to go dark.
- `seg_out`  out  7  active-high segments {g,f,e,d,c,b,a} showing the remaining count.

## Operation
- States: HOLD, RUN, DONE.
- **HOLD** (entered on `rst_in_n`=0, or on any edge sampling `cd_rst`=1):
  - prescaler = 0, remain = 0.
  - `cd_done`=0, `cd_active`=0, `cd_leds`=0, `seg_out`=7'h00 (blank).
- **HOLD -> RUN**: first edge sampling `cd_rst`=0.
  - remain = N_STEPS, prescaler = 0.
- **RUN**, each edge:
  - If prescaler == CLK_DIV-1: prescaler -> 0 and remain decrements.
  - Otherwise prescaler increments.
- **RUN -> DONE**: the edge where remain goes 1 -> 0.
- **DONE**: `cd_done`=1, `cd_active`=0, `cd_leds`=0, `seg_out`=digit 0 (7'h3F). Stays in DONE until `cd_rst`=1.
- **Outputs in RUN**:
  - `cd_active`=1.
  - `cd_leds` = (1<<remain)-1.
  - `seg_out` = decode(remain).
- **`cd_rst` priority**: `cd_rst`=1 wins over every other transition. Mid-RUN or in DONE, the next edge returns to HOLD with everything cleared. A later release restarts from N_STEPS.
- **Outputs are registered**, with no combinational path from `cd_rst` to any output.
- **Widths**:
  - prescaler is $clog2(CLK_DIV) bits.
  - remain is $clog2(N_STEPS+1) bits.
  - No wrap: remain is never decremented below 0.
- **Segment codes**: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; any other value = 00.
- **Unused state encoding** recovers to HOLD on the next edge.

## Timing
- E0 = edge entering RUN. Outputs show N_STEPS immediately after E0.
- remain decrements at edges E0 + k·CLK_DIV, for k = 1..N_STEPS.
- `cd_done` rises after edge E0 + N_STEPS·CLK_DIV, which is exactly N_STEPS·CLK_DIV cycles of RUN.
- Latency from `cd_rst` falling to `cd_active`=1 is one edge.
- Latency from `cd_rst` rising to `cd_done`=0 is one edge. The FSM leaves COUNTDOWN on the same edge it samples `cd_done`, and asserts `cd_rst` in IDLE, so `cd_done` clears one cycle later.
- Async reset takes effect immediately; the first active edge after release behaves as HOLD.

## Structure
- Shared game package holds:
  - state encodings: HOLD=2'b00, RUN=2'b01, DONE=2'b10;
  - `SEG_BLANK` and the digit-to-segment constants, also reused by the winner display.
- One sub-module, `tick_gen`:
  - inputs: `clk`, `rst_in_n`, `clr`, `en`;
  - parameter: CLK_DIV;
  - output: a one-cycle `tick` when the count equals CLK_DIV-1.
  - `countdown_timer` drives `clr` in HOLD and `en` in RUN.

## Test plan
1. **Normal countdown**, CLK_DIV=4, N_STEPS=3. Stimulus: reset, hold `cd_rst`=1 for 5 cycles, release. Expect: one edge later `cd_leds`=3'b111 and `seg_out`=4F; after 4 cycles 3'b011/5B; after 8 cycles 3'b001/06; after 12 cycles `cd_done`=1, `cd_leds`=0, `seg_out`=3F.
2. **Hold in DONE**: keep `cd_rst`=0 for 50 cycles after done. Expect `cd_done` to stay 1 with outputs unchanged. Then assert `cd_rst`: one edge later all outputs are 0.
3. **Abort mid-run**: pulse `cd_rst`=1 for 1 cycle at cycle 6 of RUN. Expect an immediate return to HOLD. On release, the count restarts at 3 and `cd_done` comes 12 cycles later, not earlier.
4. **Async reset mid-run**: drop `rst_in_n` between edges. Expect all outputs 0 with no clock edge. After release with `cd_rst`=0, expect RUN on the first edge.
5. **Parameter corners**: CLK_DIV=2, N_STEPS=1 gives `cd_done` 2 cycles after E0. CLK_DIV=5, N_STEPS=9 gives `seg_out` sequence 6F, 7F, …, 06, then 3F with `cd_done` at cycle 45.
6. **FSM integration**: connect to the game FSM. Expect RESET → COUNTDOWN → IDLE exactly N_STEPS·CLK_DIV+1 cycles after reset release, and `cd_done` low one cycle after IDLE is entered.
